// File: rtl/ser_sym_fir_mac.sv
// ser_sym_fir_mac: time-multiplexed symmetric FIR filter.
// One pre-adder, multiplier and accumulator serve the TAPS/2 coefficient pairs.
// Each accepted sample is followed by HALF MAC cycles and a 2-cycle pipeline drain.
// The result is then rounded, saturated and presented as a one-cycle out_valid pulse.
// Optional feature macro: SER_FIR_COEF_RAM_EN. When it is defined, the coefficients are
// runtime-writable while the block is idle. Otherwise they are constants taken from COEF_INIT.
`timescale 1ns/1ps
module ser_sym_fir_mac #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8,
  parameter int ACC_W  = 27,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 16,
  parameter logic [(TAPS/2)*COEF_W-1:0] COEF_INIT = {12'd41, 12'd132, 12'd341, 12'd510}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  input  logic                           coef_we,
  input  logic [$clog2(TAPS/2)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]       coef_wdata,
  output logic                           coef_wr_err,
  output logic                           out_valid,
  output logic signed [OUT_W-1:0]        out_data
);

  localparam int HALF = TAPS / 2;
  localparam int AW   = $clog2(HALF);
  localparam int PW   = DATA_W + 1;
  localparam int MW   = PW + COEF_W;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : (ACC_W+1)'(0);
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OMIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  // c[k] sits in the MSB-first packed COEF_INIT
  function automatic logic signed [COEF_W-1:0] init_coef(input int k);
    return COEF_INIT[(HALF-1-k)*COEF_W +: COEF_W];
  endfunction

  state_t                     state_q, state_d;
  logic [AW-1:0]              k_q, k_d;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [COEF_W-1:0]   c_s [HALF];
  logic                       accept_s;
  logic signed [DATA_W-1:0]   xa_s, xb_s;
  logic signed [COEF_W-1:0]   cm_s;
  logic signed [PW-1:0]       p_q, p_d;
  logic                       pv_q, pf_q;
  logic [AW-1:0]              pk_q;
  logic signed [MW-1:0]       m_q, m_d;
  logic                       mv_q, mf_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W:0]      rnd_s, shr_s;
  logic signed [OUT_W-1:0]    sat_s;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]    out_data_q, out_data_d;

  assign accept_s  = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SER_FIR_COEF_RAM_EN
  logic signed [COEF_W-1:0] c_q [HALF];
  logic                     wr_ok_s;
  logic                     wr_err_q;

  assign wr_ok_s     = coef_we & (state_q == S_IDLE) & (32'(coef_addr) < 32'(HALF));
  assign coef_wr_err = wr_err_q;

  // Coefficient register file; a write in the accept cycle already feeds that sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < HALF; j++) c_q[j] <= init_coef(j);
      wr_err_q <= 1'b0;
    end else begin
      for (int j = 0; j < HALF; j++) begin
        if (wr_ok_s && (32'(coef_addr) == 32'(j))) c_q[j] <= coef_wdata;
      end
      wr_err_q <= coef_we & ~wr_ok_s;
    end
  end

  for (genvar g = 0; g < HALF; g++) begin : g_coef
    assign c_s[g] = c_q[g];
  end
`else
  logic unused_coef_s;

  assign unused_coef_s = ^{coef_we, coef_addr, coef_wdata};
  assign coef_wr_err   = 1'b0;

  for (genvar g = 0; g < HALF; g++) begin : g_coef
    assign c_s[g] = init_coef(g);
  end
`endif

  // Sample delay line, shifted only on an accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TAPS; j++) x_q[j] <= '0;
    end else if (accept_s) begin
      x_q[0] <= in_data;
      for (int j = 1; j < TAPS; j++) x_q[j] <= x_q[j-1];
    end
  end

  // Next-state logic: IDLE -> MAC (HALF cycles) -> DRAIN -> OUT -> IDLE
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_MAC;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (k_q == AW'(HALF-1)) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      // p holds the last pair while pv_q is high; once it has moved on, acc is final next cycle
      S_DRAIN: begin
        if (!pv_q) state_d = S_OUT;
        else       state_d = S_DRAIN;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and tap-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Datapath: symmetric tap-pair select, coefficient select, pre-add, multiply, accumulate
  always_comb begin
    xa_s = '0;
    xb_s = '0;
    cm_s = '0;
    for (int j = 0; j < HALF; j++) begin
      if (k_q == AW'(j)) begin
        xa_s = x_q[j];
        xb_s = x_q[TAPS-1-j];
      end
      if (pk_q == AW'(j)) cm_s = c_s[j];
    end
    p_d = PW'(xa_s) + PW'(xb_s);
    m_d = p_q * cm_s;
    if (mv_q && mf_q)  acc_d = {{(ACC_W-MW){m_q[MW-1]}}, m_q};
    else if (mv_q)     acc_d = acc_q + {{(ACC_W-MW){m_q[MW-1]}}, m_q};
    else               acc_d = acc_q;
  end

  // Pre-add, product and accumulator pipeline with valid/first-product tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      pv_q  <= 1'b0;
      pf_q  <= 1'b0;
      pk_q  <= '0;
      m_q   <= '0;
      mv_q  <= 1'b0;
      mf_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      p_q   <= p_d;
      pv_q  <= (state_q == S_MAC);
      pf_q  <= (state_q == S_MAC) && (k_q == '0);
      pk_q  <= k_q;
      m_q   <= m_d;
      mv_q  <= pv_q;
      mf_q  <= pf_q;
      acc_q <= acc_d;
    end
  end

  // Round half-up, arithmetic shift, saturate to the output range
  always_comb begin
    rnd_s = $signed({acc_q[ACC_W-1], acc_q}) + RND;
    shr_s = rnd_s >>> SHIFT;
    if (shr_s > OMAX)      sat_s = OMAX[OUT_W-1:0];
    else if (shr_s < OMIN) sat_s = OMIN[OUT_W-1:0];
    else                   sat_s = shr_s[OUT_W-1:0];
  end

  // Output and handshake next-state: result and ready both return at the OUT edge
  always_comb begin
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (state_q == S_OUT) begin
      in_ready_d  = 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = sat_s;
    end else if (accept_s) begin
      in_ready_d = 1'b0;
    end else begin
      in_ready_d = in_ready_q;
    end
  end

  // Registered output and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
